// File: rtl/traffic_phase_scheduler.sv
// Two-street intersection phase sequencer: tick prescaler, six-phase light FSM
// with per-street priority pre-emption/extension and a flashing-yellow night mode.
module traffic_phase_scheduler #(
   parameter int unsigned TICK_DIV  = 50000000,
   parameter int unsigned GREEN_T   = 25,
   parameter int unsigned YELLOW_T  = 3,
   parameter int unsigned ALLRED_T  = 1,
   parameter int unsigned MIN_GREEN = 5,
   parameter int unsigned PRI_HOLD  = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pri_req_a,
   input  logic       pri_req_b,
   input  logic       night_mode,
   output logic [2:0] street_a,
   output logic       street_a_pri_lamp,
   output logic [2:0] street_b,
   output logic       street_b_pri_lamp,
   output logic       tick
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   typedef enum logic [2:0] {
      ALLRED_A = 3'd0,
      A_GREEN  = 3'd1,
      A_YELLOW = 3'd2,
      ALLRED_B = 3'd3,
      B_GREEN  = 3'd4,
      B_YELLOW = 3'd5,
      FLASH    = 3'd6
   } state_t;

   state_t        state, state_nxt;
   logic [7:0]    phase_cnt, cnt_nxt;
   logic          pri_mode, pri_nxt;
   logic          flash_on, flash_nxt;
   logic          pend_a, pend_b;
   logic          clr_a, clr_b;
   logic [PW-1:0] prescaler;
   logic [7:0]    dur;
   logic          done;
   logic          min_ok;

   assign tick = (prescaler == PRE_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
      end else if (tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   // Duration of the phase currently running; greens stretch to PRI_HOLD in priority mode.
   always_comb begin
      dur = 8'd1;
      case (state)
         ALLRED_A, ALLRED_B: dur = 8'(ALLRED_T);
         A_GREEN, B_GREEN:   dur = pri_mode ? 8'(PRI_HOLD) : 8'(GREEN_T);
         A_YELLOW, B_YELLOW: dur = 8'(YELLOW_T);
         default:            dur = 8'd1;
      endcase
   end

   assign done   = (phase_cnt == dur - 8'd1);
   assign min_ok = (phase_cnt >= 8'(MIN_GREEN - 1));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = phase_cnt;
      pri_nxt   = pri_mode;
      flash_nxt = flash_on;
      clr_a     = 1'b0;
      clr_b     = 1'b0;
      if (tick) begin
         if (night_mode) begin
            if (state == FLASH) begin
               flash_nxt = !flash_on;
            end else begin
               state_nxt = FLASH;
               flash_nxt = 1'b1;
               cnt_nxt   = 8'd0;
               pri_nxt   = 1'b0;
            end
         end else begin
            cnt_nxt = phase_cnt + 8'd1;
            case (state)
               FLASH: begin
                  state_nxt = ALLRED_A;
                  cnt_nxt   = 8'd0;
                  pri_nxt   = 1'b0;
                  flash_nxt = 1'b0;
               end
               ALLRED_A: if (done) begin
                  state_nxt = A_GREEN;
                  cnt_nxt   = 8'd0;
                  pri_nxt   = pend_a;
                  clr_a     = pend_a;
               end
               // Own-street extension beats cross-street pre-emption; a priority green is never cut short.
               A_GREEN: begin
                  if (!pri_mode && pend_a) begin
                     pri_nxt = 1'b1;
                     cnt_nxt = 8'd0;
                     clr_a   = 1'b1;
                  end else if ((!pri_mode && pend_b && min_ok) || done) begin
                     state_nxt = A_YELLOW;
                     cnt_nxt   = 8'd0;
                     pri_nxt   = 1'b0;
                  end
               end
               A_YELLOW: if (done) begin
                  state_nxt = ALLRED_B;
                  cnt_nxt   = 8'd0;
               end
               ALLRED_B: if (done) begin
                  state_nxt = B_GREEN;
                  cnt_nxt   = 8'd0;
                  pri_nxt   = pend_b;
                  clr_b     = pend_b;
               end
               B_GREEN: begin
                  if (!pri_mode && pend_b) begin
                     pri_nxt = 1'b1;
                     cnt_nxt = 8'd0;
                     clr_b   = 1'b1;
                  end else if ((!pri_mode && pend_a && min_ok) || done) begin
                     state_nxt = B_YELLOW;
                     cnt_nxt   = 8'd0;
                     pri_nxt   = 1'b0;
                  end
               end
               B_YELLOW: if (done) begin
                  state_nxt = ALLRED_A;
                  cnt_nxt   = 8'd0;
               end
               default: begin
                  state_nxt = ALLRED_A;
                  cnt_nxt   = 8'd0;
                  pri_nxt   = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ALLRED_A;
         phase_cnt <= 8'd0;
         pri_mode  <= 1'b0;
         flash_on  <= 1'b0;
      end else begin
         state     <= state_nxt;
         phase_cnt <= cnt_nxt;
         pri_mode  <= pri_nxt;
         flash_on  <= flash_nxt;
      end
   end

   // Requests seen while the street already holds its priority green are absorbed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_a <= 1'b0;
         pend_b <= 1'b0;
      end else if (state == FLASH || state_nxt == FLASH) begin
         pend_a <= 1'b0;
         pend_b <= 1'b0;
      end else begin
         if (clr_a) begin
            pend_a <= 1'b0;
         end else if (pri_req_a && !(state == A_GREEN && pri_mode)) begin
            pend_a <= 1'b1;
         end
         if (clr_b) begin
            pend_b <= 1'b0;
         end else if (pri_req_b && !(state == B_GREEN && pri_mode)) begin
            pend_b <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         street_a          <= LAMP_RED;
         street_b          <= LAMP_RED;
         street_a_pri_lamp <= 1'b0;
         street_b_pri_lamp <= 1'b0;
      end else begin
         street_a          <= LAMP_RED;
         street_b          <= LAMP_RED;
         street_a_pri_lamp <= 1'b0;
         street_b_pri_lamp <= 1'b0;
         case (state)
            A_GREEN: begin
               street_a          <= LAMP_GRN;
               street_a_pri_lamp <= pri_mode;
            end
            A_YELLOW: street_a <= LAMP_YEL;
            B_GREEN: begin
               street_b          <= LAMP_GRN;
               street_b_pri_lamp <= pri_mode;
            end
            B_YELLOW: street_b <= LAMP_YEL;
            FLASH: begin
               street_a <= flash_on ? LAMP_YEL : LAMP_OFF;
               street_b <= flash_on ? LAMP_YEL : LAMP_OFF;
            end
            default: ;
         endcase
      end
   end

   // A green lamp may never coexist with a green or yellow on the cross street.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(street_a[0] && (|street_b[1:0])) && !(street_b[0] && (|street_a[1:0])));
      end
   end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Table-driven bench for traffic_phase_scheduler: absolute-cycle vectors after reset
// release, plus a hand-written asynchronous reset sequence mid-yellow.
module tb_traffic_phase_scheduler;

   logic       clk;
   logic       rst_n;
   logic       pri_req_a;
   logic       pri_req_b;
   logic       night_mode;
   logic [2:0] street_a;
   logic       street_a_pri_lamp;
   logic [2:0] street_b;
   logic       street_b_pri_lamp;
   logic       tick;

   int n_cmp;
   int n_err;
   int e;

   typedef struct {
      int         at;
      logic [2:0] ea;
      logic [2:0] eb;
      logic       pa;
      logic       pb;
      logic       ra;
      logic       rb;
      logic       nm;
   } vec_t;

   vec_t tab_main[$];
   vec_t tab_rst[$];

   traffic_phase_scheduler #(
      .TICK_DIV (4),
      .GREEN_T  (5),
      .YELLOW_T (2),
      .ALLRED_T (1),
      .MIN_GREEN(2),
      .PRI_HOLD (3)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .pri_req_a        (pri_req_a),
      .pri_req_b        (pri_req_b),
      .night_mode       (night_mode),
      .street_a         (street_a),
      .street_a_pri_lamp(street_a_pri_lamp),
      .street_b         (street_b),
      .street_b_pri_lamp(street_b_pri_lamp),
      .tick             (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   function automatic vec_t mk(int at, logic [2:0] ea, logic [2:0] eb, logic pa, logic pb,
                               logic ra, logic rb, logic nm);
      vec_t v;
      v.at = at; v.ea = ea; v.eb = eb; v.pa = pa; v.pb = pb;
      v.ra = ra; v.rb = rb; v.nm = nm;
      return v;
   endfunction

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %b expected %b", name, e, act, exp);
      end
   endtask

   task automatic advance_to(input int target);
      while (e < target) begin
         @(posedge clk);
         e++;
         @(negedge clk);
         pri_req_a = 1'b0;
         pri_req_b = 1'b0;
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic exp_tick;
      advance_to(v.at);
      exp_tick = ((e % 4) == 3);
      check("street_a", street_a, v.ea);
      check("street_b", street_b, v.eb);
      check("a_pri_lamp", {2'b00, street_a_pri_lamp}, {2'b00, v.pa});
      check("b_pri_lamp", {2'b00, street_b_pri_lamp}, {2'b00, v.pb});
      check("tick", {2'b00, tick}, {2'b00, exp_tick});
      pri_req_a  = v.ra;
      pri_req_b  = v.rb;
      night_mode = v.nm;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      e = 0;
      rst_n = 1'b0;
      pri_req_a = 1'b0;
      pri_req_b = 1'b0;
      night_mode = 1'b0;

      // at, street_a, street_b, pri_a, pri_b, then inputs applied after the check
      tab_main.push_back(mk(  0, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(  3, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(  4, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(  5, 3'b001, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk( 24, 3'b001, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk( 25, 3'b010, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk( 32, 3'b010, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk( 33, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk( 37, 3'b100, 3'b001, 0, 0, 0, 0, 0));
      tab_main.push_back(mk( 56, 3'b100, 3'b001, 0, 0, 0, 0, 0));
      tab_main.push_back(mk( 57, 3'b100, 3'b010, 0, 0, 0, 0, 0));
      tab_main.push_back(mk( 65, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      // B request at A green start: pre-empts A after MIN_GREEN, B gets priority green
      tab_main.push_back(mk( 69, 3'b001, 3'b100, 0, 0, 0, 1, 0));
      tab_main.push_back(mk( 76, 3'b001, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk( 77, 3'b010, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk( 85, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk( 89, 3'b100, 3'b001, 0, 1, 0, 0, 0));
      tab_main.push_back(mk(100, 3'b100, 3'b001, 0, 1, 0, 0, 0));
      tab_main.push_back(mk(101, 3'b100, 3'b010, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(109, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      // A request during 4th green tick: A extended to 4+3 ticks
      tab_main.push_back(mk(113, 3'b001, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(125, 3'b001, 3'b100, 0, 0, 1, 0, 0));
      tab_main.push_back(mk(128, 3'b001, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(129, 3'b001, 3'b100, 1, 0, 0, 0, 0));
      tab_main.push_back(mk(140, 3'b001, 3'b100, 1, 0, 0, 0, 0));
      tab_main.push_back(mk(141, 3'b010, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(153, 3'b100, 3'b001, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(172, 3'b100, 3'b001, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(173, 3'b100, 3'b010, 0, 0, 0, 0, 0));
      // both requests together during A green: A extended, then B priority green
      tab_main.push_back(mk(185, 3'b001, 3'b100, 0, 0, 1, 1, 0));
      tab_main.push_back(mk(189, 3'b001, 3'b100, 1, 0, 0, 0, 0));
      tab_main.push_back(mk(201, 3'b010, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(213, 3'b100, 3'b001, 0, 1, 0, 0, 0));
      tab_main.push_back(mk(224, 3'b100, 3'b001, 0, 1, 0, 0, 0));
      tab_main.push_back(mk(225, 3'b100, 3'b010, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(237, 3'b001, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(256, 3'b001, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(257, 3'b010, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(269, 3'b100, 3'b001, 0, 0, 0, 0, 0));
      // night mode mid B green
      tab_main.push_back(mk(278, 3'b100, 3'b001, 0, 0, 0, 0, 1));
      tab_main.push_back(mk(280, 3'b100, 3'b001, 0, 0, 0, 0, 1));
      tab_main.push_back(mk(281, 3'b010, 3'b010, 0, 0, 0, 0, 1));
      tab_main.push_back(mk(284, 3'b010, 3'b010, 0, 0, 0, 0, 1));
      tab_main.push_back(mk(285, 3'b000, 3'b000, 0, 0, 0, 0, 1));
      tab_main.push_back(mk(289, 3'b010, 3'b010, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(292, 3'b010, 3'b010, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(293, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      // B request then reset lands mid A yellow with pend_b still set
      tab_main.push_back(mk(297, 3'b001, 3'b100, 0, 0, 0, 1, 0));
      tab_main.push_back(mk(304, 3'b001, 3'b100, 0, 0, 0, 0, 0));
      tab_main.push_back(mk(305, 3'b010, 3'b100, 0, 0, 0, 0, 0));

      tab_rst.push_back(mk(  0, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tab_rst.push_back(mk(  4, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tab_rst.push_back(mk(  5, 3'b001, 3'b100, 0, 0, 0, 0, 0));
      tab_rst.push_back(mk( 25, 3'b010, 3'b100, 0, 0, 0, 0, 0));
      tab_rst.push_back(mk( 33, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tab_rst.push_back(mk( 37, 3'b100, 3'b001, 0, 0, 0, 0, 0));
      tab_rst.push_back(mk( 57, 3'b100, 3'b010, 0, 0, 0, 0, 0));

      // clock/reset
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      e = 0;

      for (int i = 0; i < tab_main.size(); i++) begin
         run_vec(tab_main[i]);
      end

      // asynchronous reset between clock edges, mid A yellow
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_street_a", street_a, 3'b100);
      check("async_rst_street_b", street_b, 3'b100);
      check("async_rst_a_pri", {2'b00, street_a_pri_lamp}, 3'b000);
      check("async_rst_b_pri", {2'b00, street_b_pri_lamp}, 3'b000);
      check("async_rst_tick", {2'b00, tick}, 3'b000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      e = 0;

      for (int i = 0; i < tab_rst.size(); i++) begin
         run_vec(tab_rst[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
